seq_det_ctrl: RTL



---
 rtl/seq_det_pkg.sv | 12 +
 rtl/seq_det_if.sv | 30 +++
 rtl/seq_det_match.sv | 54 +++++
 rtl/seq_det_ctrl.sv | 101 ++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and default sizes for the programmable sequence detector.
package seq_det_pkg;
   localparam int PAT_W_DEF = 8;
   localparam int LEN_W_DEF = 4;
   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/seq_det_if.sv
// Config, command, serial-stream and status bundle of the sequence detector.
interface seq_det_if import seq_det_pkg::*; #(
   parameter int PAT_W = PAT_W_DEF,
   parameter int LEN_W = LEN_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) ();
   logic             cfg_we;
   logic [PAT_W-1:0] cfg_pattern;
   logic [LEN_W-1:0] cfg_len;
   logic [CNT_W-1:0] cfg_limit;
   logic             start;
   logic             stop;
   logic             bit_valid;
   logic             bit_in;
   logic             match;
   logic [CNT_W-1:0] match_count;
   logic             busy;
   logic             done;
   logic             cfg_err;

   modport master (
      output cfg_we, cfg_pattern, cfg_len, cfg_limit, start, stop, bit_valid, bit_in,
      input  match, match_count, busy, done, cfg_err
   );

   modport slave (
      input  cfg_we, cfg_pattern, cfg_len, cfg_limit, start, stop, bit_valid, bit_in,
      output match, match_count, busy, done, cfg_err
   );
endinterface

// File: rtl/seq_det_match.sv
// History shift register, fill counter and masked Mealy compare.
// SEQ_DET_OVERLAP_EN keeps history/fill after a match (overlapping detection).
module seq_det_match import seq_det_pkg::*; #(
   parameter int PAT_W = PAT_W_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_scan,
   input  logic             i_bit_valid,
   input  logic             i_bit_in,
   input  logic [PAT_W-1:0] i_pattern,
   input  logic [LEN_W-1:0] i_len,
   output logic             o_match
);
   localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);

   logic [PAT_W-1:0] r_hist;
   logic [LEN_W-1:0] r_fill;
   logic [PAT_W-1:0] w_cand;
   logic [PAT_W-1:0] w_mask;
   logic [LEN_W-1:0] w_fill_inc;
   logic             w_shift;
   logic             w_fill_ok;

   assign w_shift    = i_scan & i_bit_valid;
   assign w_cand     = {r_hist[PAT_W-2:0], i_bit_in};
   assign w_fill_inc = (r_fill == FILL_MAX) ? r_fill : r_fill + LEN_W'(1);
   // fill+1 >= len is fill >= len-1 without underflow when len is 0
   assign w_fill_ok  = ({1'b0, r_fill} + (LEN_W+1)'(1)) >= {1'b0, i_len};

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < PAT_W; i++)
         w_mask[i] = (LEN_W'(i) < i_len);
   end

   assign o_match = w_shift & w_fill_ok & (((w_cand ^ i_pattern) & w_mask) == '0);

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_hist <= '0;
         r_fill <= '0;
      end else if (w_shift) begin
         r_hist <= w_cand;
`ifdef SEQ_DET_OVERLAP_EN
         r_fill <= w_fill_inc;
`else
         r_fill <= o_match ? '0 : w_fill_inc;
`endif
      end
   end
endmodule

// File: rtl/seq_det_ctrl.sv
// Sequence-detection controller: config registers, IDLE/SCAN/DONE FSM, match counter.
// Detection overlap is selected by SEQ_DET_OVERLAP_EN inside seq_det_match.
module seq_det_ctrl import seq_det_pkg::*; #(
   parameter int PAT_W = PAT_W_DEF,
   parameter int LEN_W = LEN_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic     clk,
   input  logic     rst,
   seq_det_if.slave bus
);
   state_t           r_state;
   state_t           w_next;
   logic [PAT_W-1:0] r_pattern;
   logic [LEN_W-1:0] r_len;
   logic [CNT_W-1:0] r_limit;
   logic [CNT_W-1:0] r_count;
   logic             r_cfg_err;

   logic             w_len_ok;
   logic             w_start_ok;
   logic             w_start_bad;
   logic             w_match;
   logic [CNT_W-1:0] w_count_inc;
   logic             w_limit_hit;
   logic             w_busy;
   logic             w_done;

   assign w_len_ok    = (r_len != '0) && (r_len <= LEN_W'(PAT_W));
   assign w_start_ok  = (r_state == IDLE) && bus.start && w_len_ok;
   assign w_start_bad = (r_state == IDLE) && bus.start && !w_len_ok;
   assign w_count_inc = (r_count == '1) ? r_count : r_count + CNT_W'(1);
   assign w_limit_hit = w_match && (r_limit != '0) && (w_count_inc == r_limit);

   seq_det_match #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_match (
      .clk         (clk),
      .rst         (rst),
      .i_clr       (w_start_ok),
      .i_scan      (r_state == SCAN),
      .i_bit_valid (bus.bit_valid),
      .i_bit_in    (bus.bit_in),
      .i_pattern   (r_pattern),
      .i_len       (r_len),
      .o_match     (w_match)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_start_ok) w_next = SCAN;
         SCAN:    if (bus.stop || w_limit_hit) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         SCAN:    w_busy = 1'b1;
         DONE:    w_done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pattern <= '0;
         r_len     <= '0;
         r_limit   <= '0;
      end else if (r_state == IDLE && bus.cfg_we) begin
         r_pattern <= bus.cfg_pattern;
         r_len     <= bus.cfg_len;
         r_limit   <= bus.cfg_limit;
      end
   end

   // A match in a stop cycle is still counted; stop only decides the exit.
   always_ff @(posedge clk) begin
      if (rst)             r_count <= '0;
      else if (w_start_ok) r_count <= '0;
      else if (w_match)    r_count <= w_count_inc;
   end

   always_ff @(posedge clk) begin
      if (rst) r_cfg_err <= 1'b0;
      else     r_cfg_err <= w_start_bad;
   end

   assign bus.match       = w_match;
   assign bus.match_count = r_count;
   assign bus.busy        = w_busy;
   assign bus.done        = w_done;
   assign bus.cfg_err     = r_cfg_err;
endmodule
